// File: rtl/fifo_pkg.sv
// Shared FIFO pointer definitions, used by both the read-side and write-side pointer blocks.
package fifo_pkg;

    localparam int ADDR_W = 7;
    localparam int PTR_W  = 8;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/rd_ptr_empty.sv
// Read-side pointer and empty-flag block of an asynchronous FIFO.
// Optional occupancy / almost-empty outputs are compiled in with macro RD_OCC_EN.
module rd_ptr_empty
    import fifo_pkg::*;
#(
    parameter int AE_THRESH = 4
) (
    input  logic              r_clk,
    input  logic              rst,
    input  logic              r_enable,
    input  logic [PTR_W-1:0]  w_count_sync,
    output logic [PTR_W-1:0]  r_count,
    output logic [ADDR_W-1:0] r_addr,
    output logic              empty,
`ifdef RD_OCC_EN
    output logic              underflow,
    output logic [PTR_W-1:0]  rd_occ,
    output logic              almost_empty
`else
    output logic              underflow
`endif
);

    if (AE_THRESH < 0 || AE_THRESH > 127) begin : g_bad_thresh
        $error("rd_ptr_empty: AE_THRESH out of range 0..127");
    end

    logic [PTR_W-1:0] r_bin;
    logic             w_pop;
    logic [PTR_W-1:0] w_bin_next;
    logic [PTR_W-1:0] w_gray_next;

    // Popping is gated by the registered empty flag, so a request while empty is dropped.
    assign w_pop       = r_enable & ~empty;
    assign w_bin_next  = r_bin + PTR_W'(w_pop);
    assign w_gray_next = bin2gray(w_bin_next);

    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_count   <= '0;
            r_addr    <= '0;
            empty     <= 1'b1;
            underflow <= 1'b0;
        end else begin
            r_bin     <= w_bin_next;
            r_count   <= w_gray_next;
            r_addr    <= w_bin_next[ADDR_W-1:0];
            empty     <= (w_gray_next == w_count_sync);
            if (r_enable && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef RD_OCC_EN
    localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

    logic [PTR_W-1:0] w_wr_bin;
    logic [PTR_W-1:0] w_occ_next;

    gray2bin #(
        .W (PTR_W)
    ) u_gray2bin (
        .i_gray (w_count_sync),
        .o_bin  (w_wr_bin)
    );

    assign w_occ_next = w_wr_bin - w_bin_next;

    always_ff @(posedge r_clk) begin
        if (rst) begin
            rd_occ       <= '0;
            almost_empty <= 1'b1;
        end else begin
            rd_occ       <= w_occ_next;
            almost_empty <= (w_occ_next <= AE_T);
        end
    end
`endif

endmodule
